// File: rtl/inst_fetch_queue.sv
// Instruction decoupling queue between fetch and decode/issue: circular buffer
// of {pc, inst} entries with multi-lane enqueue, partial dequeue and branch flush.
module inst_fetch_queue #(
  parameter  int unsigned FETCH_W = 2,
  parameter  int unsigned ISSUE_W = 2,
  parameter  int unsigned DEPTH   = 8,
  localparam int unsigned CW      = $clog2(DEPTH + 1),
  localparam int unsigned EW      = $clog2(FETCH_W + 1),
  localparam int unsigned IW      = $clog2(ISSUE_W + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 flush_keep,
  input  logic                 enq_valid,
  input  logic [EW-1:0]        enq_count,
  input  logic [31:0]          enq_pc,
  input  logic [32*FETCH_W-1:0] enq_inst,
  output logic                 enq_ready,
  output logic [ISSUE_W-1:0]   deq_valid,
  output logic [32*ISSUE_W-1:0] deq_pc,
  output logic [32*ISSUE_W-1:0] deq_inst,
  input  logic [IW-1:0]        deq_take,
  output logic [CW-1:0]        count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [31:0]   r_pc   [DEPTH];
  logic [31:0]   r_inst [DEPTH];

  logic [PW-1:0] w_occ;
  logic [PW-1:0] w_take;
  logic [EW-1:0] w_enq_n;
  logic          w_enq_fire;
  logic [PW-1:0] w_head_nxt;
  logic [PW-1:0] w_tail_nxt;

  // Pointers carry one extra bit so full (occ == DEPTH) differs from empty.
  assign w_occ     = r_tail - r_head;
  assign count     = CW'(w_occ);
  assign enq_ready = (DEPTH - 32'(w_occ)) >= FETCH_W;

  always_comb begin
    w_enq_n    = (32'(enq_count) > FETCH_W) ? EW'(FETCH_W) : enq_count;
    w_take     = (32'(deq_take) > 32'(w_occ)) ? w_occ : PW'(deq_take);
    w_enq_fire = enq_valid & enq_ready & (enq_count != '0) & ~flush;

    w_head_nxt = r_head + w_take;
    w_tail_nxt = r_tail;
    if (flush) begin
      if (!flush_keep) begin
        w_head_nxt = r_tail;
      end else if (w_take != w_occ) begin
        // Delay-slot keep: only the oldest surviving entry stays queued.
        w_tail_nxt = w_head_nxt + PW'(1);
      end else begin
        w_tail_nxt = w_head_nxt;
      end
    end else if (w_enq_fire) begin
      w_tail_nxt = r_tail + PW'(w_enq_n);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      for (int unsigned i = 0; i < FETCH_W; i++) begin
        if (i < 32'(w_enq_n)) begin
          r_pc[r_tail[AW-1:0] + AW'(i)]   <= enq_pc + (i << 2);
          r_inst[r_tail[AW-1:0] + AW'(i)] <= enq_inst[32*i +: 32];
        end
      end
    end
  end

  always_comb begin
    deq_valid = '0;
    deq_pc    = '0;
    deq_inst  = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      if (32'(w_occ) > i) begin
        deq_valid[i]       = 1'b1;
        deq_pc[32*i +: 32]   = r_pc[r_head[AW-1:0] + AW'(i)];
        deq_inst[32*i +: 32] = r_inst[r_head[AW-1:0] + AW'(i)];
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int unsigned FW = 2;
  localparam int unsigned IS = 2;
  localparam int unsigned D  = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        flush_keep = 1'b0;
  logic        enq_valid = 1'b0;
  logic [1:0]  enq_count = '0;
  logic [31:0] enq_pc = '0;
  logic [63:0] enq_inst = '0;
  logic        enq_ready;
  logic [1:0]  deq_valid;
  logic [63:0] deq_pc;
  logic [63:0] deq_inst;
  logic [1:0]  deq_take = '0;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] mq[$];

  always #5 clk = ~clk;

  inst_fetch_queue #(.FETCH_W(FW), .ISSUE_W(IS), .DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .flush_keep(flush_keep),
    .enq_valid(enq_valid), .enq_count(enq_count), .enq_pc(enq_pc),
    .enq_inst(enq_inst), .enq_ready(enq_ready), .deq_valid(deq_valid),
    .deq_pc(deq_pc), .deq_inst(deq_inst), .deq_take(deq_take), .count(count)
  );

  // Reference model: one clock edge applied to a queue of {pc, inst}.
  function automatic void model_step();
    int unsigned sz, n, tk;
    logic rdy;
    sz  = mq.size();
    rdy = (D - sz) >= FW;
    n   = (enq_count > FW) ? FW : enq_count;
    tk  = (deq_take > sz) ? sz : deq_take;
    if (flush && !flush_keep) begin
      mq.delete();
    end else begin
      repeat (tk) void'(mq.pop_front());
      if (flush) begin
        while (mq.size() > 1) void'(mq.pop_back());
      end else if (enq_valid && rdy) begin
        for (int i = 0; i < int'(n); i++)
          mq.push_back({enq_pc + 32'(4 * i), enq_inst[32*i +: 32]});
      end
    end
  endfunction

  function automatic logic [1:0] m_valid();
    logic [1:0] v = '0;
    for (int i = 0; i < int'(IS); i++) if (i < mq.size()) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] m_pc();
    logic [63:0] v = '0;
    for (int i = 0; i < int'(IS); i++) if (i < mq.size()) v[32*i +: 32] = mq[i][63:32];
    return v;
  endfunction

  function automatic logic [63:0] m_inst();
    logic [63:0] v = '0;
    for (int i = 0; i < int'(IS); i++) if (i < mq.size()) v[32*i +: 32] = mq[i][31:0];
    return v;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; flush_keep = 1'b0; enq_valid = 1'b0;
    enq_count = '0; deq_take = '0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    mq.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic enq_group(input logic [31:0] pc, input logic [1:0] n);
    enq_valid = 1'b1; enq_count = n; enq_pc = pc;
    enq_inst = {$urandom, $urandom};
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    #2;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (deq_valid !== 2'b00) begin n_bad++; $display("FAIL reset_valid: got %b expected 00", deq_valid); end
    n_cmp++; if (deq_pc !== 64'd0) begin n_bad++; $display("FAIL reset_pc: got %h expected 0", deq_pc); end
    n_cmp++; if (deq_inst !== 64'd0) begin n_bad++; $display("FAIL reset_inst: got %h expected 0", deq_inst); end
    n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", enq_ready); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    mq.delete();
  endtask

  task automatic test_first_enq();
    do_reset();
    enq_valid = 1'b1; enq_count = 2'd2; enq_pc = 32'hBFC00000;
    enq_inst = {32'h24020002, 32'h24010001};
    #1;
    n_cmp++; if (deq_valid !== 2'b00) begin n_bad++; $display("FAIL no_bypass: got %b expected 00", deq_valid); end
    tick();
    idle();
    n_cmp++; if (deq_valid !== 2'b11) begin n_bad++; $display("FAIL first_valid: got %b expected 11", deq_valid); end
    n_cmp++; if (deq_pc !== {32'hBFC00004, 32'hBFC00000}) begin n_bad++; $display("FAIL first_pc: got %h expected bfc00004bfc00000", deq_pc); end
    n_cmp++; if (deq_inst !== {32'h24020002, 32'h24010001}) begin n_bad++; $display("FAIL first_inst: got %h expected 2402000224010001", deq_inst); end
    n_cmp++; if (count !== 4'd2) begin n_bad++; $display("FAIL first_count: got %0d expected 2", count); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int g = 0; g < 4; g++) begin
      enq_group(32'h1000 + 32'(8 * g), 2'd2);
      n_cmp++; if (count !== 4'(2 * (g + 1))) begin n_bad++; $display("FAIL fill_count[%0d]: got %0d expected %0d", g, count, 2 * (g + 1)); end
      n_cmp++; if (enq_ready !== (g < 3)) begin n_bad++; $display("FAIL fill_ready[%0d]: got %b expected %b", g, enq_ready, g < 3); end
    end
    enq_group(32'h2000, 2'd2);
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fill_hold_count: got %0d expected 8", count); end
    n_cmp++; if (deq_pc[31:0] !== 32'h1000) begin n_bad++; $display("FAIL fill_hold_pc: got %h expected 00001000", deq_pc[31:0]); end
    deq_take = 2'd2;
    tick();
    idle();
    n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL fill_take_count: got %0d expected 6", count); end
    n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL fill_take_ready: got %b expected 1", enq_ready); end
    n_cmp++; if (deq_pc[31:0] !== 32'h1008) begin n_bad++; $display("FAIL fill_take_pc: got %h expected 00001008", deq_pc[31:0]); end
    // count 7 also refuses a 2-wide group
    enq_group(32'h3000, 2'd1);
    n_cmp++; if (enq_ready !== 1'b0 || count !== 4'd7) begin n_bad++; $display("FAIL fill_seven: got ready=%b count=%0d expected ready=0 count=7", enq_ready, count); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      enq_valid = 1'b1; enq_count = 2'd2; enq_pc = 32'(8 * k);
      enq_inst = {$urandom, $urandom}; deq_take = 2'd2;
      tick();
      n_cmp++; if (deq_pc[31:0] !== 32'(8 * k)) begin n_bad++; $display("FAIL wrap_pc[%0d]: got %h expected %h", k, deq_pc[31:0], 32'(8 * k)); end
      n_cmp++; if (deq_inst !== m_inst() || count !== 4'd2) begin n_bad++; $display("FAIL wrap_data[%0d]: got inst=%h count=%0d expected inst=%h count=2", k, deq_inst, count, m_inst()); end
    end
    idle();
  endtask

  task automatic test_partial();
    do_reset();
    enq_group(32'h200, 2'd2);
    enq_group(32'h208, 2'd2);
    enq_group(32'h210, 2'd1);
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL partial_fill: got %0d expected 5", count); end
    deq_take = 2'd1; tick(); idle();
    n_cmp++; if (count !== 4'd4 || deq_pc[31:0] !== 32'h204) begin n_bad++; $display("FAIL partial_take1: got count=%0d pc=%h expected count=4 pc=00000204", count, deq_pc[31:0]); end
    deq_take = 2'd2; tick(); idle();
    n_cmp++; if (count !== 4'd2 || deq_pc !== {32'h210, 32'h20C}) begin n_bad++; $display("FAIL partial_take2: got count=%0d pc=%h expected count=2 pc=000002100000020c", count, deq_pc); end
    deq_take = 2'd3; tick(); idle();
    n_cmp++; if (count !== 4'd0 || deq_valid !== 2'b00) begin n_bad++; $display("FAIL partial_clamp: got count=%0d valid=%b expected count=0 valid=00", count, deq_valid); end
  endtask

  task automatic test_flush_keep();
    do_reset();
    enq_group(32'h100, 2'd2);
    enq_group(32'h108, 2'd2);
    deq_take = 2'd1; flush = 1'b1; flush_keep = 1'b1;
    enq_valid = 1'b1; enq_count = 2'd2; enq_pc = 32'h500;
    tick();
    idle();
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL keep_count: got %0d expected 1", count); end
    n_cmp++; if (deq_pc !== {32'h0, 32'h104}) begin n_bad++; $display("FAIL keep_pc: got %h expected 0000000000000104", deq_pc); end
    n_cmp++; if (deq_valid !== 2'b01) begin n_bad++; $display("FAIL keep_valid: got %b expected 01", deq_valid); end
    deq_take = 2'd1; flush = 1'b1; flush_keep = 1'b1;
    tick();
    idle();
    n_cmp++; if (count !== 4'd0 || deq_valid !== 2'b00) begin n_bad++; $display("FAIL keep_empty: got count=%0d valid=%b expected count=0 valid=00", count, deq_valid); end
  endtask

  task automatic test_flush_plain_reset();
    do_reset();
    for (int g = 0; g < 3; g++) enq_group(32'h400 + 32'(8 * g), 2'd2);
    flush = 1'b1; deq_take = 2'd2; enq_valid = 1'b1; enq_count = 2'd2;
    tick();
    idle();
    n_cmp++; if (count !== 4'd0 || deq_valid !== 2'b00) begin n_bad++; $display("FAIL flush_plain: got count=%0d valid=%b expected count=0 valid=00", count, deq_valid); end
    enq_group(32'h600, 2'd2);
    enq_group(32'h608, 2'd2);
    n_cmp++; if (count !== 4'd4) begin n_bad++; $display("FAIL refill: got %0d expected 4", count); end
    #3;
    resetn = 1'b0;
    mq.delete();
    #1;
    n_cmp++; if (count !== 4'd0 || deq_valid !== 2'b00 || enq_ready !== 1'b1) begin n_bad++; $display("FAIL async_reset_ctl: got count=%0d valid=%b ready=%b expected 0/00/1", count, deq_valid, enq_ready); end
    n_cmp++; if (deq_pc !== 64'd0 || deq_inst !== 64'd0) begin n_bad++; $display("FAIL async_reset_data: got pc=%h inst=%h expected 0/0", deq_pc, deq_inst); end
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    enq_group(32'h700, 2'd2);
    n_cmp++; if (count !== 4'd2 || deq_pc !== {32'h704, 32'h700}) begin n_bad++; $display("FAIL post_reset_enq: got count=%0d pc=%h expected count=2 pc=0000070400000700", count, deq_pc); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      enq_valid  = ($urandom_range(0, 3) != 0);
      enq_count  = 2'($urandom_range(0, 3));
      enq_pc     = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      enq_inst   = {$urandom, $urandom};
      deq_take   = 2'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 15) == 0);
      flush_keep = $urandom_range(0, 1) != 0;
      tick();
      n_cmp++; if (count !== 4'(mq.size()) || enq_ready !== ((D - mq.size()) >= FW)) begin n_bad++; $display("FAIL rnd_ctl[%0d]: got count=%0d ready=%b expected count=%0d ready=%b", c, count, enq_ready, mq.size(), (D - mq.size()) >= FW); end
      n_cmp++; if (deq_valid !== m_valid()) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, deq_valid, m_valid()); end
      n_cmp++; if (deq_pc !== m_pc() || deq_inst !== m_inst()) begin n_bad++; $display("FAIL rnd_data[%0d]: got pc=%h inst=%h expected pc=%h inst=%h", c, deq_pc, deq_inst, m_pc(), m_inst()); end
    end
    idle();
  endtask

  initial begin
    #1;
    test_reset();
    test_first_enq();
    test_fill();
    test_wrap();
    test_partial();
    test_flush_keep();
    test_flush_plain_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
